// File: rtl/mac_pkg.sv
// Shared types and default latencies for the MAC issue/writeback-tag controller.
package mac_pkg;

  localparam int DEF_LANES   = 4;
  localparam int DEF_IDX_W   = 5;
  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_ADD_LAT = 7;

  // Writeback tag at the default lane count and index width.
  typedef struct packed {
    logic                 valid;
    logic                 reg_wen;
    logic [DEF_LANES-1:0] word_sel;
    logic [DEF_IDX_W-1:0] index;
  } tag_t;

  typedef enum logic {
    OP_MAC = 1'b0,
    OP_ADD = 1'b1
  } op_kind_e;

endpackage

// File: rtl/mac_slot_pipe.sv
// L-deep writeback slot shifter: slot[1] is the current writeback, MACs enter at slot[L],
// add-only ops enter at slot[ADD_LAT]; slot[ADD_LAT+1] occupancy is exposed for hazard checks.
module mac_slot_pipe #(
  parameter int L       = 12,
  parameter int ADD_LAT = 7,
  parameter int DAT_W   = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ins_mac_i,
  input  logic             ins_add_i,
  input  logic [DAT_W-1:0] tag_dat_i,
  output logic             head_vld_o,
  output logic [DAT_W-1:0] head_dat_o,
  output logic             probe_vld_o
);

  logic [L:1]       vld_q;
  logic [L:1]       vld_d;
  logic [DAT_W-1:0] dat_q [1:L];
  logic [DAT_W-1:0] dat_d [1:L];

  always_comb begin
    vld_d = '0;
    for (int k = 1; k <= L; k++) begin
      dat_d[k] = '0;
    end
    for (int k = 1; k < L; k++) begin
      vld_d[k] = vld_q[k+1];
      dat_d[k] = dat_q[k+1];
    end
    if (ins_mac_i) begin
      vld_d[L] = 1'b1;
      dat_d[L] = tag_dat_i;
    end
    // ADD_LAT < L always, so the two insertion points never coincide.
    if (ins_add_i) begin
      vld_d[ADD_LAT] = 1'b1;
      dat_d[ADD_LAT] = tag_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int k = 1; k <= L; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 1; k <= L; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign head_vld_o  = vld_q[1];
  assign head_dat_o  = dat_q[1];
  assign probe_vld_o = vld_q[ADD_LAT+1];

endmodule

// File: rtl/mac_issue_ctrl.sv
// Issue control for the MAC lanes: valid/ready accept, writeback tag tracking, add-only
// collision stall, fences, in-flight count and sticky per-lane NaN flags.
module mac_issue_ctrl
  import mac_pkg::*;
#(
  parameter  int LANES   = DEF_LANES,
  parameter  int IDX_W   = DEF_IDX_W,
  parameter  int MUL_LAT = DEF_MUL_LAT,
  parameter  int ADD_LAT = DEF_ADD_LAT,
  localparam int L       = MUL_LAT + ADD_LAT,
  localparam int CNT_W   = $clog2(L + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_add_only,
  input  logic             in_add_sub,
  input  logic             in_fence,
  input  logic             in_reg_wen,
  input  logic [LANES-1:0] in_word_sel,
  input  logic [IDX_W-1:0] in_index,
  output logic             dp_valid,
  output logic             dp_add_only,
  output logic             dp_add_sub,
  input  logic [LANES-1:0] dp_nan,
  output logic             wb_valid,
  output logic             wb_reg_wen,
  output logic [LANES-1:0] wb_word_sel,
  output logic [IDX_W-1:0] wb_index,
  output logic [LANES-1:0] nan_flags,
  input  logic             nan_clr,
  output logic             empty,
  output logic [CNT_W-1:0] outstanding
);

  localparam int DAT_W = 1 + LANES + IDX_W;

  op_kind_e         op_kind;
  logic             accept;
  logic             probe_vld;
  logic             head_vld;
  logic [DAT_W-1:0] head_dat;
  logic             head_rw;
  logic [LANES-1:0] head_ws;
  logic [IDX_W-1:0] head_idx;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [LANES-1:0] nan_q;
  logic [LANES-1:0] nan_d;

  assign op_kind = in_add_only ? OP_ADD : OP_MAC;
  assign empty   = (cnt_q == '0);

  // An add-only landing on a slot already owned by an older MAC must wait a cycle.
  assign in_ready = !(op_kind == OP_ADD && probe_vld) && !(in_fence && !empty);
  assign accept   = in_valid && in_ready;

  assign dp_valid    = accept;
  assign dp_add_only = in_add_only;
  assign dp_add_sub  = in_add_sub;

  mac_slot_pipe #(
    .L       (L),
    .ADD_LAT (ADD_LAT),
    .DAT_W   (DAT_W)
  ) u_slot_pipe (
    .clk_i       (CLK),
    .rst_i       (RST),
    .ins_mac_i   (accept && op_kind == OP_MAC),
    .ins_add_i   (accept && op_kind == OP_ADD),
    .tag_dat_i   ({in_reg_wen, in_word_sel, in_index}),
    .head_vld_o  (head_vld),
    .head_dat_o  (head_dat),
    .probe_vld_o (probe_vld)
  );

  assign {head_rw, head_ws, head_idx} = head_dat;

  assign wb_valid    = head_vld;
  assign wb_reg_wen  = head_vld && head_rw;
  assign wb_word_sel = head_vld ? head_ws : '0;
  assign wb_index    = head_vld ? head_idx : '0;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, head_vld})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A NaN arriving in the same cycle as a clear survives it.
  always_comb begin
    nan_d = nan_clr ? '0 : nan_q;
    if (head_vld) begin
      nan_d = nan_d | dp_nan;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      nan_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      nan_q <= nan_d;
    end
  end

  assign outstanding = cnt_q;
  assign nan_flags   = nan_q;

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// Scoreboard bench for mac_issue_ctrl: ops are modelled by their retire cycle; a negedge monitor checks writebacks, count and NaN flags.
module tb_mac_issue_ctrl;
  import mac_pkg::*;

  localparam int LANES   = 4;
  localparam int IDX_W   = 5;
  localparam int MUL_LAT = 5;
  localparam int ADD_LAT = 7;
  localparam int L       = MUL_LAT + ADD_LAT;
  localparam int CW      = $clog2(L + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_add_only = 1'b0;
  logic             in_add_sub = 1'b0;
  logic             in_fence = 1'b0;
  logic             in_reg_wen = 1'b0;
  logic [LANES-1:0] in_word_sel = '0;
  logic [IDX_W-1:0] in_index = '0;
  logic             dp_valid;
  logic             dp_add_only;
  logic             dp_add_sub;
  logic [LANES-1:0] dp_nan = '0;
  logic             wb_valid;
  logic             wb_reg_wen;
  logic [LANES-1:0] wb_word_sel;
  logic [IDX_W-1:0] wb_index;
  logic [LANES-1:0] nan_flags;
  logic             nan_clr = 1'b0;
  logic             empty;
  logic [CW-1:0]    outstanding;

  mac_issue_ctrl #(
    .LANES   (LANES),
    .IDX_W   (IDX_W),
    .MUL_LAT (MUL_LAT),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_add_only (in_add_only),
    .in_add_sub  (in_add_sub),
    .in_fence    (in_fence),
    .in_reg_wen  (in_reg_wen),
    .in_word_sel (in_word_sel),
    .in_index    (in_index),
    .dp_valid    (dp_valid),
    .dp_add_only (dp_add_only),
    .dp_add_sub  (dp_add_sub),
    .dp_nan      (dp_nan),
    .wb_valid    (wb_valid),
    .wb_reg_wen  (wb_reg_wen),
    .wb_word_sel (wb_word_sel),
    .wb_index    (wb_index),
    .nan_flags   (nan_flags),
    .nan_clr     (nan_clr),
    .empty       (empty),
    .outstanding (outstanding)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int   acc;
    int   ret;
    tag_t tag;
  } op_t;

  op_t              inflight[$];
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  logic [LANES-1:0] nan_m = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: an op is in flight from the cycle after its accept through its retire cycle.
  always @(negedge CLK) begin
    int   hit;
    int   n_out;
    tag_t et;
    if (RST) begin
      nan_m = '0;
    end else begin
      hit   = -1;
      n_out = 0;
      foreach (inflight[i]) begin
        if (inflight[i].acc < cyc && inflight[i].ret >= cyc) n_out++;
        if (inflight[i].ret == cyc && hit < 0) hit = i;
      end
      chk("wb_valid", 32'(wb_valid), 32'(hit >= 0));
      if (hit >= 0) begin
        et = inflight[hit].tag;
        chk("wb_index", 32'(wb_index), 32'(et.index));
        chk("wb_word_sel", 32'(wb_word_sel), 32'(et.word_sel));
        chk("wb_reg_wen", 32'(wb_reg_wen), 32'(et.reg_wen));
        inflight.delete(hit);
      end else begin
        chk("wb_idle_tag", 32'({wb_reg_wen, wb_word_sel, wb_index}), 32'(0));
      end
      chk("outstanding", 32'(outstanding), 32'(n_out));
      chk("empty", 32'(empty), 32'(n_out == 0));
      chk("nan_flags", 32'(nan_flags), 32'(nan_m));
      nan_m = (nan_clr ? '0 : nan_m) | ((hit >= 0) ? dp_nan : '0);
    end
  end

  // One cycle of stimulus; returns whether the reference model expects an accept.
  task automatic drive(input logic v, input logic ao, input logic asb, input logic f,
                       input logic rw, input logic [LANES-1:0] ws, input logic [IDX_W-1:0] idx,
                       input logic clr, input logic [LANES-1:0] nan, output logic acc);
    logic exp_rdy;
    logic blk_add;
    logic blk_f;
    op_t  e;
    @(posedge CLK);
    #1;
    in_valid = v; in_add_only = ao; in_add_sub = asb; in_fence = f;
    in_reg_wen = rw; in_word_sel = ws; in_index = idx;
    nan_clr = clr; dp_nan = nan;
    #1;
    blk_add = 1'b0;
    blk_f   = 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].ret == cyc + ADD_LAT) blk_add = 1'b1;
      if (inflight[i].ret >= cyc) blk_f = 1'b1;
    end
    exp_rdy = !(ao && blk_add) && !(f && blk_f);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    chk("dp_valid", 32'(dp_valid), 32'(acc));
    if (acc) begin
      chk("dp_add_only", 32'(dp_add_only), 32'(ao));
      e.acc          = cyc;
      e.ret          = cyc + (ao ? ADD_LAT : L);
      e.tag.valid    = 1'b1;
      e.tag.reg_wen  = rw;
      e.tag.word_sel = ws;
      e.tag.index    = idx;
      inflight.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic clr, input logic [LANES-1:0] nan);
    logic a;
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, clr, nan, a);
  endtask

  task automatic offer(input logic ao, input logic f, input logic rw,
                       input logic [LANES-1:0] ws, input logic [IDX_W-1:0] idx);
    logic a;
    logic asb;
    int   n;
    a   = 1'b0;
    n   = 0;
    asb = 1'($urandom);
    while (!a && n < 40) begin
      drive(1'b1, ao, asb, f, rw, ws, idx, 1'b0, '0, a);
      n++;
    end
    if (!a) begin
      vectors++;
      miscompares++;
      $display("FAIL offer_timeout cyc=%0d got=no_accept expected=accept", cyc);
    end
  endtask

  initial begin
    logic             a;
    logic             pend;
    logic             v, ao, asb, f, rw;
    logic [LANES-1:0] ws;
    logic [IDX_W-1:0] idx;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_outstanding", 32'(outstanding), 32'(0));
    chk("rst_wb", 32'({wb_valid, wb_reg_wen, wb_word_sel, wb_index}), 32'(0));
    chk("rst_nan", 32'(nan_flags), 32'(0));
    @(posedge CLK);
    #1 RST = 1'b0;

    // Single MAC.
    offer(1'b0, 1'b0, 1'b1, 4'b0001, 5'd3);
    idle(15, 1'b0, '0);

    // Add-only colliding with an older MAC stalls one cycle.
    offer(1'b0, 1'b0, 1'b1, 4'b0010, 5'd9);
    idle(4, 1'b0, '0);
    offer(1'b1, 1'b0, 1'b1, 4'b0100, 5'd10);
    idle(15, 1'b0, '0);

    // Full-rate MAC burst filling every slot.
    for (int i = 0; i < L; i++) offer(1'b0, 1'b0, 1'(i), 4'(1 << (i % LANES)), 5'(i));
    idle(L + 3, 1'b0, '0);

    // Fenced add-only behind three MACs.
    for (int i = 0; i < 3; i++) offer(1'b0, 1'b0, 1'b1, 4'b1000, 5'(20 + i));
    offer(1'b1, 1'b1, 1'b0, 4'b0011, 5'd31);
    idle(10, 1'b0, '0);

    // Sticky NaN, then set-wins against a simultaneous clear.
    idle(1, 1'b1, '0);
    offer(1'b0, 1'b0, 1'b1, 4'b1111, 5'd1);
    offer(1'b0, 1'b0, 1'b1, 4'b1111, 5'd2);
    idle(10, 1'b0, '0);
    idle(1, 1'b0, 4'b0100);
    idle(1, 1'b1, 4'b0001);
    idle(3, 1'b0, '0);

    // Reset with MACs in flight drops them all.
    for (int i = 0; i < 4; i++) offer(1'b0, 1'b0, 1'b1, 4'b0101, 5'(i));
    @(posedge CLK);
    #1;
    RST = 1'b1; in_valid = 1'b0; nan_clr = 1'b0; dp_nan = '0;
    #1;
    chk("rst_mid_outstanding", 32'(outstanding), 32'(0));
    chk("rst_mid_empty", 32'(empty), 32'(1));
    chk("rst_mid_wb", 32'(wb_valid), 32'(0));
    inflight.delete();
    @(posedge CLK);
    #1 RST = 1'b0;
    idle(L + 8, 1'b0, '0);

    // Random traffic; the payload is held while offered and not accepted.
    pend = 1'b0;
    v = 1'b0; ao = 1'b0; asb = 1'b0; f = 1'b0; rw = 1'b0; ws = '0; idx = '0;
    repeat (1500) begin
      if (!pend) begin
        v   = ($urandom % 3) != 0;
        ao  = 1'($urandom);
        asb = 1'($urandom);
        f   = ($urandom % 16) == 0;
        rw  = 1'($urandom);
        ws  = 4'($urandom);
        idx = 5'($urandom);
      end
      drive(v, ao, asb, f, rw, ws, idx, ($urandom % 32) == 0,
            (($urandom % 4) == 0) ? 4'($urandom) : 4'b0, a);
      pend = v && !a;
    end
    idle(L + 4, 1'b0, '0);
    chk("drained", 32'(inflight.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
